node_init_loader: RTL
=====================

// Module: node_init_loader
// PURPOSE
//  Reader/sequencer for the combinational initial-displacement LUT of the 30x1 drum string.
//  On a start pulse (reset or pluck), walks LUT addresses 0..N_NODES-1 and captures each node value.
//  Applies an amplitude shift and streams the values as a write port into the solver node RAMs.
//  The same word goes to u_n and u_nm1, so the string starts with zero velocity.
//  Signals done when finished; the solver stays stalled while busy is high.
// PARAMETERS
//  N_NODES  30  number of nodes loaded; LUT addresses 0..N_NODES-1
//  ADDR_W   5   width of lut_addr / wr_addr; must satisfy 2**ADDR_W >= N_NODES
//  DATA_W   32  node word width, signed fixed point (1.0 = 32'h20000)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high
//  start      in   1       1-cycle request to (re)load all nodes; ignored while busy
//  amp_shift  in   3       arithmetic right shift applied to LUT data; sampled on accepted start
//  lut_addr   out  ADDR_W  address driven to LUT, registered
//  lut_data   in   DATA_W  LUT output, combinational from lut_addr (valid same cycle)
//  wr_en      out  1       write request to node RAMs, registered
//  wr_addr    out  ADDR_W  node index of current write
//  wr_data    out  DATA_W  lut_data >>> amp_shift (sign-extended)
//  wr_ready   in   1       RAM/arbiter accepts the write on a clock edge where wr_en && wr_ready
//  busy       out  1       high from accepted start until done
//  done       out  1       1-cycle pulse after the last write is accepted
// BEHAVIOUR
//  Reset (async): state=IDLE, idx=0, lut_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, shift reg=0.
//  FSM:
//   IDLE  - start=1 -> FETCH; idx=0; lut_addr=0; busy=1; latch amp_shift.
//   FETCH - pipeline advance when (!wr_en || wr_ready):
//             wr_en<=1, wr_addr<=lut_addr, wr_data<=lut_data>>>shift.
//             If idx==N_NODES-1 -> DRAIN; else idx++ and lut_addr<=idx+1.
//           Otherwise (stalled) hold idx, lut_addr and all wr_* outputs.
//   DRAIN - when wr_ready: wr_en<=0, busy<=0, done<=1 -> IDLE.
//  done: exactly one cycle; busy falls on the same edge done rises.
//  Latency with wr_ready=1, start sampled at edge k:
//   - wr_en high for edges k+1..k+N_NODES, one write accepted per cycle;
//   - done high for the cycle after edge k+N_NODES+1;
//   - total N_NODES+2 cycles, start to done.
//  Write ordering: wr_addr strictly 0,1,..,N_NODES-1. No address is skipped or repeated.
//   No address >= N_NODES is ever driven on lut_addr or wr_addr.
//  Backpressure: wr_addr/wr_data stay stable while wr_en && !wr_ready. No write is dropped.
//  Shift: arithmetic (sign-preserving). amp_shift=0 passes data unchanged.
//   amp_shift changes while busy have no effect.
//  start while busy: ignored, no restart, no extra done.
//   start in the cycle done is high: accepted (state already IDLE).
//  Reset mid-load: all outputs return to reset values immediately and no done is issued.
//   A later start reloads from address 0.
// TESTING
//  1. start, amp_shift=0, wr_ready=1 -> 30 writes, addr 0..29.
//     addr1=32'h00924, addr14=addr15=32'h08000, addr29=0; done 32 cycles after start edge.
//  2. amp_shift=2 -> addr7 data 32'h01000, addr14 32'h02000.
//     Negative LUT stub 32'hFFFF8000 >>> 2 = 32'hFFFFE000.
//  3. wr_ready low 3 cycles at addr 10 -> wr_addr=10 and its data held stable.
//     Still exactly 30 unique writes; done delayed by 3 cycles.
//  4. start re-pulsed at addr 5 while busy -> ignored: single sequence, single done.
//     start on the done cycle -> second full load of 30 writes.
//  5. reset asserted at addr 12 -> wr_en=0, busy=0 asynchronously, no done.
//     New start -> writes restart at addr 0.
//  6. Scoreboard throughout: wr_addr never >=30, busy==(state!=IDLE), done never high 2 consecutive cycles.

Source files
------------

// File: rtl/node_init_loader_if.sv
// Bus between the initial-displacement loader, its LUT and the solver node RAM write port.
`timescale 1ns/1ps
interface node_init_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        amp_shift;
    logic [ADDR_W-1:0] lut_addr;
    logic [DATA_W-1:0] lut_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              busy;
    logic              done;

    // Loader side: drives the LUT address and the node RAM write port.
    modport master (
        input  start, amp_shift, lut_data, wr_ready,
        output lut_addr, wr_en, wr_addr, wr_data, busy, done
    );

    // Environment side: control, LUT and RAM/arbiter.
    modport slave (
        output start, amp_shift, lut_data, wr_ready,
        input  lut_addr, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/node_init_loader.sv
// Walks the initial-displacement LUT for every string node, scales each value by an
// arithmetic right shift and streams it out as a write to the solver node RAMs.
// The write port is a one-deep pipeline stage that holds under backpressure.
`timescale 1ns/1ps
module node_init_loader #(
    parameter int N_NODES = 30,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    node_init_loader_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NODES - 1);

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] lut_addr_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [2:0]        shift_reg;

    // The pipeline stage may advance when it is empty or its word is being taken now.
    logic                     advance;
    logic signed [DATA_W-1:0] scaled;

    assign advance = !wr_en_reg || bus.wr_ready;
    assign scaled  = $signed(bus.lut_data) >>> shift_reg;

    assign bus.lut_addr = lut_addr_reg;
    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data  = wr_data_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;

    // Load sequencer: IDLE waits for start, FETCH streams one node per accepted slot,
    // DRAIN waits for the final write to be accepted before signalling done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            lut_addr_reg <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            shift_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        state_reg    <= ST_FETCH;
                        idx_reg      <= '0;
                        lut_addr_reg <= '0;
                        busy_reg     <= 1'b1;
                        shift_reg    <= bus.amp_shift;
                    end
                end
                ST_FETCH: begin
                    if (advance) begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= lut_addr_reg;
                        wr_data_reg <= scaled;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            idx_reg      <= idx_reg + 1'b1;
                            lut_addr_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.wr_ready) begin
                        wr_en_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
